pipe_stage_skid: RTL and testbench

- Parametrised pipeline stage register with a valid/ready handshake and a one-entry skid buffer.
- Successor to the fixed-width IF/ID latch: arbitrary payload width, back-pressure without a combinational ready path, flush, and saturating stall/flush counters for performance monitoring.
- Sits between any two CPU pipeline stages (IF/ID, ID/EX, ...); one instance per stage boundary.

---
 rtl/pipe_stage_skid.sv | 95 +++++++++
 tb/tb_pipe_stage_skid.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, one-entry skid buffer,
// flush, and saturating stall/flush performance counters.
module pipe_stage_skid #(
    parameter int               WIDTH     = 96,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    input  logic             flush,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic             r_main_v;
    logic             r_skid_v;
    logic [WIDTH-1:0] r_main_d;
    logic [WIDTH-1:0] r_skid_d;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_stall_inc;
    logic w_flush_inc;

    // in_ready comes straight from a flop, so there is no out_ready->in_ready path
    assign in_ready  = !r_skid_v;
    assign out_valid = r_main_v;
    assign out_data  = r_main_d;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

    assign w_stall_inc = r_main_v && !out_ready && !flush;
    assign w_flush_inc = flush && (r_main_v || r_skid_v);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_main_v <= 1'b0;
            r_skid_v <= 1'b0;
            r_main_d <= RESET_VAL;
            r_skid_d <= RESET_VAL;
        end else if (flush) begin
            r_main_v <= 1'b0;
            r_skid_v <= 1'b0;
            r_main_d <= RESET_VAL;
            r_skid_d <= RESET_VAL;
        end else if (!r_main_v) begin
            if (in_valid) begin
                r_main_v <= 1'b1;
                r_main_d <= in_data;
            end
        end else if (!r_skid_v) begin
            if (out_ready) begin
                if (in_valid) begin
                    r_main_d <= in_data;
                end else begin
                    r_main_v <= 1'b0;
                end
            end else if (in_valid) begin
                r_skid_v <= 1'b1;
                r_skid_d <= in_data;
            end
        end else if (out_ready) begin
            // Skid entry is older than anything upstream, so it refills main first
            r_main_d <= r_skid_d;
            r_skid_v <= 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (cnt_clr) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_inc && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_flush_inc && (r_flush_cnt != {CNT_W{1'b1}})) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    a_no_orphan_skid: assert property (@(posedge CLK) disable iff (RST) !(r_skid_v && !r_main_v));

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed self-checking bench for pipe_stage_skid: streaming, skid back-pressure,
// flush, counter clear/saturation and asynchronous reset.
module tb_pipe_stage_skid;

    localparam int          WIDTH = 32;
    localparam logic [31:0] RVAL  = 32'hDEAD_BEEF;

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic        flush;
    logic        cnt_clr;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    logic        s_in_ready;
    logic        s_out_valid;
    logic [31:0] s_out_data;
    logic [3:0]  s_stall_cnt;
    logic [3:0]  s_flush_cnt;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    pipe_stage_skid #(.WIDTH(WIDTH), .RESET_VAL(RVAL), .CNT_W(16)) dut (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .flush(flush), .cnt_clr(cnt_clr),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_stage_skid #(.WIDTH(WIDTH), .RESET_VAL(RVAL), .CNT_W(4)) dut_sat (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid), .in_data(in_data), .in_ready(s_in_ready),
        .out_valid(s_out_valid), .out_data(s_out_data), .out_ready(out_ready),
        .flush(flush), .cnt_clr(cnt_clr),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_all();
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b1; cnt_clr = 1'b1;
        step();
        flush = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_data !== RVAL) begin errors++; $display("FAIL reset_out_data: got %h expected %h", out_data, RVAL); end
        checks++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin errors++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", stall_cnt, flush_cnt); end
        #12 RST = 1'b0;
        step();
    endtask

    task automatic test_stream();
        clear_all();
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_data = i;
            step();
            $display("stream: sent %0d, out_valid=%b out_data=%0d in_ready=%b", i, out_valid, out_data, in_ready);
            checks++; if (out_valid !== 1'b1 || out_data !== 32'(i)) begin errors++; $display("FAIL stream_out_%0d: got v=%b d=%h expected v=1 d=%h", i, out_valid, out_data, i); end
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready_%0d: got %b expected 1", i, in_ready); end
        end
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain: got out_valid=%b expected 0", out_valid); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL stream_stall_cnt: got %0d expected 0", stall_cnt); end
    endtask

    task automatic test_backpressure();
        clear_all();
        in_valid = 1'b1; in_data = 32'hA; out_ready = 1'b0;
        step();
        checks++; if (out_valid !== 1'b1 || out_data !== 32'hA || in_ready !== 1'b1) begin errors++; $display("FAIL bp_load_a: got v=%b d=%h rdy=%b expected v=1 d=a rdy=1", out_valid, out_data, in_ready); end
        in_data = 32'hB;
        step();
        checks++; if (in_ready !== 1'b0 || out_data !== 32'hA) begin errors++; $display("FAIL bp_skid: got rdy=%b d=%h expected rdy=0 d=a", in_ready, out_data); end
        in_valid = 1'b0;
        step();
        checks++; if (out_data !== 32'hA || stall_cnt !== 16'd2) begin errors++; $display("FAIL bp_hold: got d=%h stall=%0d expected d=a stall=2", out_data, stall_cnt); end
        out_ready = 1'b1;
        step();
        $display("backpressure: delivered a, out_data now %h", out_data);
        checks++; if (out_valid !== 1'b1 || out_data !== 32'hB || in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_b: got v=%b d=%h rdy=%b expected v=1 d=b rdy=1", out_valid, out_data, in_ready); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got out_valid=%b expected 0", out_valid); end
        checks++; if (stall_cnt !== 16'd2) begin errors++; $display("FAIL bp_stall_cnt: got %0d expected 2", stall_cnt); end
    endtask

    task automatic test_flush_skid();
        clear_all();
        in_valid = 1'b1; in_data = 32'hA;
        step();
        in_data = 32'hB;
        step();
        in_data = 32'hC; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || out_data !== RVAL || in_ready !== 1'b1) begin errors++; $display("FAIL flush_skid_state: got v=%b d=%h rdy=%b expected v=0 d=%h rdy=1", out_valid, out_data, in_ready, RVAL); end
        checks++; if (flush_cnt !== 16'd1) begin errors++; $display("FAIL flush_skid_cnt: got %0d expected 1", flush_cnt); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_deliver_%0d: got v=%b d=%h expected v=0", i, out_valid, out_data); end
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++; if (flush_cnt !== 16'd1) begin errors++; $display("FAIL flush_empty_cnt: got %0d expected 1", flush_cnt); end
    endtask

    task automatic test_cnt_clr();
        clear_all();
        in_valid = 1'b1; in_data = 32'h55; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL clr_pre_stall: got %0d expected 1", stall_cnt); end
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL clr_wins: got %0d expected 0", stall_cnt); end
        step();
        checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL clr_resume: got %0d expected 1", stall_cnt); end
    endtask

    task automatic test_saturation();
        clear_all();
        in_valid = 1'b1; in_data = 32'h77; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 15) begin
                checks++; if (s_stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_at_15: got %0d expected 15", s_stall_cnt); end
            end
        end
        checks++; if (s_stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_no_wrap: got %0d expected 15", s_stall_cnt); end
        checks++; if (stall_cnt !== 16'd20) begin errors++; $display("FAIL sat_wide_cnt: got %0d expected 20", stall_cnt); end
        checks++; if (s_out_data !== 32'h77 || s_out_valid !== 1'b1 || s_in_ready !== 1'b1) begin errors++; $display("FAIL sat_payload: got v=%b d=%h expected v=1 d=77", s_out_valid, s_out_data); end
    endtask

    task automatic test_async_reset();
        clear_all();
        in_valid = 1'b1; in_data = 32'hA;
        step();
        in_data = 32'hB;
        step();
        in_valid = 1'b0;
        #2 RST = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== RVAL) begin errors++; $display("FAIL async_rst_state: got v=%b rdy=%b d=%h expected v=0 rdy=1 d=%h", out_valid, in_ready, out_data, RVAL); end
        checks++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin errors++; $display("FAIL async_rst_cnt: got %0d/%0d expected 0/0", stall_cnt, flush_cnt); end
        #2 RST = 1'b0;
        out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h5;
        step();
        in_data = 32'h6;
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h5) begin errors++; $display("FAIL async_resume_5: got v=%b d=%h expected v=1 d=5", out_valid, out_data); end
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h6) begin errors++; $display("FAIL async_resume_6: got v=%b d=%h expected v=1 d=6", out_valid, out_data); end
        step();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush_skid();
        test_cnt_clr();
        test_saturation();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
